// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator-style cpu_core: opcodes, flag bit
// positions, ALU operation and operand-select encodings.
package cpu_pkg;

  localparam logic [6:0] OP_NOP    = 7'h00;
  localparam logic [6:0] OP_MOV_AB = 7'h01;
  localparam logic [6:0] OP_MOV_BA = 7'h02;
  localparam logic [6:0] OP_LDI_A  = 7'h03;
  localparam logic [6:0] OP_LDI_B  = 7'h04;
  localparam logic [6:0] OP_ADD_A  = 7'h05;
  localparam logic [6:0] OP_ADD_B  = 7'h06;
  localparam logic [6:0] OP_ADDI   = 7'h07;
  localparam logic [6:0] OP_SUB    = 7'h08;
  localparam logic [6:0] OP_SUBI   = 7'h09;
  localparam logic [6:0] OP_AND    = 7'h0A;
  localparam logic [6:0] OP_OR     = 7'h0B;
  localparam logic [6:0] OP_XOR    = 7'h0C;
  localparam logic [6:0] OP_NOT    = 7'h0D;
  localparam logic [6:0] OP_SHL    = 7'h0E;
  localparam logic [6:0] OP_SHR    = 7'h0F;
  localparam logic [6:0] OP_ST     = 7'h10;
  localparam logic [6:0] OP_LD     = 7'h11;
  localparam logic [6:0] OP_CMP    = 7'h12;
  localparam logic [6:0] OP_CMPI   = 7'h13;
  localparam logic [6:0] OP_JMP    = 7'h14;
  localparam logic [6:0] OP_JEQ    = 7'h15;
  localparam logic [6:0] OP_JNE    = 7'h16;
  localparam logic [6:0] OP_JLT    = 7'h17;
  localparam logic [6:0] OP_JCS    = 7'h18;
  localparam logic [6:0] OP_HLT    = 7'h7F;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    ALU_PASS,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOT,
    ALU_SHL,
    ALU_SHR
  } alu_op_e;

  typedef enum logic [1:0] {
    OPND_A,
    OPND_B,
    OPND_K,
    OPND_MEM
  } opnd_sel_e;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: result of a <op> b plus Z/N/C/V status.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  alu_op_e       op,
  output logic [DW-1:0] result,
  output logic          z,
  output logic          n,
  output logic          c,
  output logic          v
);

  logic [DW:0] sum;

  always_comb begin
    sum    = '0;
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (op)
      ALU_PASS: result = b;
      ALU_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[DW-1:0];
        c      = sum[DW];
        v      = (a[DW-1] == b[DW-1]) && (result[DW-1] != a[DW-1]);
      end
      // The extra top bit of the widened difference is the unsigned borrow.
      ALU_SUB: begin
        sum    = {1'b0, a} - {1'b0, b};
        result = sum[DW-1:0];
        c      = sum[DW];
        v      = (a[DW-1] != b[DW-1]) && (result[DW-1] != a[DW-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_NOT: result = ~a;
      ALU_SHL: begin
        result = {a[DW-2:0], 1'b0};
        c      = a[DW-1];
      end
      ALU_SHR: begin
        result = {1'b0, a[DW-1:1]};
        c      = a[0];
      end
      default: result = b;
    endcase
  end

  assign z = (result == '0);
  assign n = result[DW-1];

endmodule

// File: rtl/cpu_core.sv
// Single-cycle accumulator core: two registers, registered flags, small data
// memory, conditional jumps and a sticky halt.
module cpu_core
  import cpu_pkg::*;
#(
  parameter int DW       = 8,
  parameter int PW       = 8,
  parameter int DM_DEPTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  output logic [PW-1:0] instr_addr,
  input  logic [DW+7:0] instr_data,
  output logic [DW-1:0] alu_out,
  output logic [DW-1:0] reg_a,
  output logic [DW-1:0] reg_b,
  output logic [3:0]    flags,
  output logic          halted
);

  localparam int AW = (DM_DEPTH > 1) ? $clog2(DM_DEPTH) : 1;

  typedef enum logic {ST_RUN, ST_HALT} state_e;

  state_e state, state_next;

  logic [PW-1:0] pc;
  logic [6:0]    opcode;
  logic [DW-1:0] k;
  logic          unused_mode_bit;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] mem [DM_DEPTH];
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] operand;

  alu_op_e   alu_op;
  opnd_sel_e opnd_sel;
  logic      wr_a, wr_b, flag_we, mem_we, take_jump, do_halt;
  logic      alu_z, alu_n, alu_c, alu_v;
  logic      run;

  assign opcode          = instr_data[DW+7:DW+1];
  assign k               = instr_data[DW-1:0];
  assign unused_mode_bit = instr_data[DW];
  assign dm_addr         = k[AW-1:0];
  assign mem_rdata       = mem[dm_addr];
  assign run             = (state == ST_RUN);
  assign halted          = (state == ST_HALT);
  assign instr_addr      = pc;

  always_comb begin
    case (opnd_sel)
      OPND_A:  operand = reg_a;
      OPND_B:  operand = reg_b;
      OPND_K:  operand = k;
      default: operand = mem_rdata;
    endcase
  end

  cpu_alu #(.DW(DW)) u_alu (
    .a      (reg_a),
    .b      (operand),
    .op     (alu_op),
    .result (alu_out),
    .z      (alu_z),
    .n      (alu_n),
    .c      (alu_c),
    .v      (alu_v)
  );

  // Every register write goes through the ALU; moves and loads use PASS.
  always_comb begin
    alu_op    = ALU_PASS;
    opnd_sel  = OPND_B;
    wr_a      = 1'b0;
    wr_b      = 1'b0;
    flag_we   = 1'b0;
    mem_we    = 1'b0;
    take_jump = 1'b0;
    do_halt   = 1'b0;
    case (opcode)
      OP_MOV_AB: wr_a = 1'b1;
      OP_MOV_BA: begin opnd_sel = OPND_A; wr_b = 1'b1; end
      OP_LDI_A:  begin opnd_sel = OPND_K; wr_a = 1'b1; end
      OP_LDI_B:  begin opnd_sel = OPND_K; wr_b = 1'b1; end
      OP_ADD_A:  begin alu_op = ALU_ADD; wr_a = 1'b1; flag_we = 1'b1; end
      OP_ADD_B:  begin alu_op = ALU_ADD; wr_b = 1'b1; flag_we = 1'b1; end
      OP_ADDI:   begin alu_op = ALU_ADD; opnd_sel = OPND_K; wr_a = 1'b1; flag_we = 1'b1; end
      OP_SUB:    begin alu_op = ALU_SUB; wr_a = 1'b1; flag_we = 1'b1; end
      OP_SUBI:   begin alu_op = ALU_SUB; opnd_sel = OPND_K; wr_a = 1'b1; flag_we = 1'b1; end
      OP_AND:    begin alu_op = ALU_AND; wr_a = 1'b1; flag_we = 1'b1; end
      OP_OR:     begin alu_op = ALU_OR;  wr_a = 1'b1; flag_we = 1'b1; end
      OP_XOR:    begin alu_op = ALU_XOR; wr_a = 1'b1; flag_we = 1'b1; end
      OP_NOT:    begin alu_op = ALU_NOT; wr_a = 1'b1; flag_we = 1'b1; end
      OP_SHL:    begin alu_op = ALU_SHL; wr_a = 1'b1; flag_we = 1'b1; end
      OP_SHR:    begin alu_op = ALU_SHR; wr_a = 1'b1; flag_we = 1'b1; end
      OP_ST:     mem_we = 1'b1;
      OP_LD:     begin opnd_sel = OPND_MEM; wr_a = 1'b1; end
      OP_CMP:    begin alu_op = ALU_SUB; flag_we = 1'b1; end
      OP_CMPI:   begin alu_op = ALU_SUB; opnd_sel = OPND_K; flag_we = 1'b1; end
      OP_JMP:    take_jump = 1'b1;
      OP_JEQ:    take_jump = flags[FLAG_Z];
      OP_JNE:    take_jump = ~flags[FLAG_Z];
      OP_JLT:    take_jump = flags[FLAG_N] ^ flags[FLAG_V];
      OP_JCS:    take_jump = flags[FLAG_C];
      OP_HLT:    do_halt = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == ST_RUN && do_halt) state_next = ST_HALT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= '0;
      reg_a <= '0;
      reg_b <= '0;
      flags <= '0;
    end else if (run) begin
      pc <= take_jump ? PW'(k) : pc + PW'(1);
      if (wr_a)    reg_a <= alu_out;
      if (wr_b)    reg_b <= alu_out;
      if (flag_we) flags <= {alu_z, alu_n, alu_c, alu_v};
    end
  end

  // Memory has no reset; contents survive reset and halt.
  always_ff @(posedge clk) begin
    if (!reset && run && mem_we) mem[dm_addr] <= reg_a;
  end

endmodule

// File: doc/cpu_core.md
CPU_CORE -- requirements
Module: cpu_core

Interface
REQ-001 Parameter DW, default 8, data/register/literal width in bits (>=4).
REQ-002 Parameter PW, default 8, program-counter and instruction-address width.
REQ-003 Parameter DM_DEPTH, default 16, data-memory word count (power of two, <=2**DW).
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 instr_addr  out  PW  current PC, drives external instruction memory.
REQ-007 instr_data  in  DW+8  instruction (combinational read): opcode=[DW+7:DW+1], bit DW ignored, K=[DW-1:0].
REQ-008 alu_out  out  DW  current-cycle ALU result (combinational).
REQ-009 reg_a, reg_b  out  DW each  architectural registers A and B.
REQ-010 flags  out  4  registered status {Z,N,C,V}, bit 3 = Z.
REQ-011 halted  out  1  high while core is stopped by HLT.

Function
REQ-012 Core SHALL execute one instruction per clock while not halted; results visible the cycle after fetch.
REQ-013 Opcodes (hex) SHALL be: 00 NOP; 01 A=B; 02 B=A; 03 A=K; 04 B=K; 05 A=A+B; 06 B=A+B; 07 A=A+K; 08 A=A-B; 09 A=A-K; 0A A=A&B; 0B A=A|B; 0C A=A^B; 0D A=~A; 0E A=A<<1; 0F A=A>>1 (logical); 10 MEM[K]=A; 11 A=MEM[K]; 12 CMP A,B; 13 CMP A,K; 14 JMP K; 15 JEQ K; 16 JNE K; 17 JLT K; 18 JCS K; 7F HLT.
REQ-014 Unlisted opcodes SHALL behave as NOP.
REQ-015 Arithmetic SHALL be DW-bit modulo; C = carry-out for add, borrow (A<operand unsigned) for subtract/CMP, shifted-out bit for shifts, 0 for logic ops.
REQ-016 V SHALL be two's-complement overflow for add/subtract/CMP, 0 otherwise; Z = result==0; N = result MSB.
REQ-017 Flags SHALL update only on opcodes 05-0F, 12, 13; all other opcodes SHALL hold flags.
REQ-018 CMP SHALL compute A-operand, update flags, write no register.
REQ-019 PC SHALL increment by 1 modulo 2**PW; PC PW'(2**PW-1) wraps to 0.
REQ-020 Jump target SHALL be K zero-extended/truncated to PW; JEQ on Z=1, JNE on Z=0, JLT on N^V=1, JCS on C=1, using flags registered before the jump.
REQ-021 Data-memory address SHALL be K modulo DM_DEPTH; store write synchronous; load read combinational from the array.
REQ-022 Store then load of same address in consecutive cycles SHALL return the stored value.
REQ-023 HLT SHALL set halted next edge; while halted, PC, A, B, flags and memory SHALL hold regardless of instr_data.
REQ-024 Register/memory destinations not named by the opcode SHALL hold.

Reset
REQ-025 On reset edge: PC=0, A=0, B=0, flags=0000, halted=0.
REQ-026 Reset SHALL dominate any instruction or halt in the same cycle, including mid-program and while halted.
REQ-027 Data-memory contents SHALL NOT be cleared by reset; contents undefined until written.

Structure
REQ-028 Shared package cpu_pkg SHALL hold opcode constants, flag bit indices and the ALU-operation enum.
REQ-029 ALU and flag generation SHALL be a sub-module cpu_alu (operands, op, DW parameter -> result, Z, N, C, V).
REQ-030 Decoder SHALL be combinational inside cpu_core; no other sub-modules.

Verification (DW=8, PW=8, DM_DEPTH=16)
REQ-031 Reset then 03 K=7F, 07 K=01 -> A=80, flags Z=0 N=1 C=0 V=1.
REQ-032 A=05, 13 K=05, 15 K=20 -> Z=1, next instr_addr=20; repeat with K=06 in CMP -> JEQ falls through to PC+1, C=1.
REQ-033 A=3C, 10 K=13, 03 K=00, 11 K=03 -> A=3C (address wraps mod 16).
REQ-034 Program at 00: 7F; then 10 cycles varied instr_data -> halted=1, PC=01, A/B/flags unchanged; assert reset -> all REQ-025 values next edge.
REQ-035 14 K=FF then NOP -> PC FF then 00; opcode 55 -> no state change except PC.
REQ-036 Reset asserted same cycle as 05 with A=B=01 -> A=00, flags=0000.
